alu_cmd_sequencer: RTL

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

---
 rtl/alu_cmd_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// alu_cmd_sequencer
// Accepts one ALU command at a time and drives its operands and mode to an
// external combinational ALU. It waits SETTLE_CYCLES clocks for the result,
// captures it, and holds it until the consumer takes it.
//
// Ports
//   clk        system clock, rising-edge active
//   reset      asynchronous reset, active low
//   cmd_valid  command present on cmd_mode/cmd_a/cmd_b
//   cmd_ready  sequencer idle and able to accept a command
//   cmd_mode   ALU operation (0 die, 10 add, 11 a-b, 12 multiply)
//   cmd_a/b    operands
//   alu_a/b    operand drive to the ALU (held until the next acceptance)
//   alu_mode   mode drive to the ALU
//   alu_inc    one-cycle die-advance pulse, only for mode 0
//   alu_out    ALU result
//   res_valid  captured result available
//   res_ready  consumer accepts the result
//   res_data   captured result (kept after the handshake)
//   res_mode   mode tag of res_data
//   op_count   completed-operation counter, wraps at 256
module alu_cmd_sequencer #(
  parameter int SETTLE_CYCLES = 2  // legal range 1..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_mode,
  input  logic [5:0] cmd_a,
  input  logic [5:0] cmd_b,
  output logic [5:0] alu_a,
  output logic [5:0] alu_b,
  output logic [3:0] alu_mode,
  output logic       alu_inc,
  input  logic [7:0] alu_out,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_mode,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, RESULT} state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       cmd_ready_reg, cmd_ready_next;
  logic [5:0] alu_a_reg, alu_a_next;
  logic [5:0] alu_b_reg, alu_b_next;
  logic [3:0] alu_mode_reg, alu_mode_next;
  logic       alu_inc_reg, alu_inc_next;
  logic       res_valid_reg, res_valid_next;
  logic [7:0] res_data_reg, res_data_next;
  logic [3:0] res_mode_reg, res_mode_next;
  logic [7:0] op_count_reg, op_count_next;
  logic       accept;

  // cmd_ready is registered, so it stays low on the first edge after reset
  // release and no command can slip in before the sequencer is ready.
  assign accept = (state_reg == IDLE) && cmd_valid && cmd_ready_reg;

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      cmd_ready_reg <= 1'b0;
      alu_a_reg     <= '0;
      alu_b_reg     <= '0;
      alu_mode_reg  <= '0;
      alu_inc_reg   <= 1'b0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
      res_mode_reg  <= '0;
      op_count_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cmd_ready_reg <= cmd_ready_next;
      alu_a_reg     <= alu_a_next;
      alu_b_reg     <= alu_b_next;
      alu_mode_reg  <= alu_mode_next;
      alu_inc_reg   <= alu_inc_next;
      res_valid_reg <= res_valid_next;
      res_data_reg  <= res_data_next;
      res_mode_reg  <= res_mode_next;
      op_count_reg  <= op_count_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = DRIVE;
      DRIVE:   state_next = SETTLE;
      SETTLE:  if (cnt_reg == 4'd0) state_next = RESULT;
      RESULT:  if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output
  always_comb begin
    cnt_next       = cnt_reg;
    alu_a_next     = alu_a_reg;
    alu_b_next     = alu_b_reg;
    alu_mode_next  = alu_mode_reg;
    alu_inc_next   = 1'b0;
    res_valid_next = res_valid_reg;
    res_data_next  = res_data_reg;
    res_mode_next  = res_mode_reg;
    op_count_next  = op_count_reg;
    // Looking at state_next lets cmd_ready drop on the acceptance edge and
    // rise on the handshake edge, so it is never high outside IDLE.
    cmd_ready_next = (state_next == IDLE);
    case (state_reg)
      IDLE: begin
        if (accept) begin
          alu_a_next    = cmd_a;
          alu_b_next    = cmd_b;
          alu_mode_next = cmd_mode;
          // Set on the acceptance edge so the pulse covers exactly DRIVE
          alu_inc_next  = (cmd_mode == 4'd0);
        end
      end
      DRIVE: begin
        cnt_next = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_reg == 4'd0) begin
          res_data_next  = alu_out;
          res_mode_next  = alu_mode_reg;
          res_valid_next = 1'b1;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      RESULT: begin
        if (res_ready) begin
          res_valid_next = 1'b0;
          op_count_next  = op_count_reg + 8'd1;
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready = cmd_ready_reg;
  assign alu_a     = alu_a_reg;
  assign alu_b     = alu_b_reg;
  assign alu_mode  = alu_mode_reg;
  assign alu_inc   = alu_inc_reg;
  assign res_valid = res_valid_reg;
  assign res_data  = res_data_reg;
  assign res_mode  = res_mode_reg;
  assign op_count  = op_count_reg;

endmodule
